// File: rtl/fixed_to_posit_pipe.sv
// Signed fixed-point to posit converter, 3 register stages, 1 word/cycle; all stages stall together on out_ready low.
// Define FX2P_STATUS_EN to add the out_inexact / out_sat status outputs.
module fixed_to_posit_pipe #(
    parameter int N  = 16,
    parameter int FB = 14,
    parameter int PN = 16,
    parameter int ES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_fixed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PN-1:0] out_posit
`ifdef FX2P_STATUS_EN
    ,
    output logic          out_inexact,
    output logic          out_sat
`endif
);

    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int SW   = PW + 2;
    localparam int TW   = ES + N;
    localparam int VW   = PN + TW + N + 4;
    localparam int PADW = VW - 2 - TW;

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic [N-1:0]  mag;
        logic [PW-1:0] p;
    } s1_t;

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic [PN-2:0] body;
        logic          guard;
        logic          sticky;
    } s2_t;

    logic          adv;
    logic          v1, v2, v3;
    s1_t           s1_d, s1_q;
    s2_t           s2_d, s2_q;
    logic [PN-1:0] posit_d, posit_q;

    assign adv       = out_ready | ~v3;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign out_posit = posit_q;

    // ---------------- S1: sign, magnitude, MSB position ----------------
    logic [N-1:0] mag_c;
    logic [PW:0]  lzc_c;
    logic         found_c;

    assign mag_c = in_fixed[N-1] ? (~in_fixed + N'(1)) : in_fixed;

    always_comb begin
        lzc_c   = '0;
        found_c = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found_c) begin
                if (mag_c[i]) found_c = 1'b1;
                else          lzc_c   = lzc_c + (PW+1)'(1);
            end
        end
    end

    always_comb begin
        s1_d.sign = in_fixed[N-1];
        s1_d.zero = (mag_c == '0);
        s1_d.mag  = mag_c;
        s1_d.p    = PW'((PW+1)'(N - 1) - lzc_c);
    end

    // ---------------- S2: scale, regime, unrounded body ----------------
    logic signed [SW-1:0] s_c, k_c;
    logic        [SW-1:0] sh_c;
    logic        [PW:0]   fs_c;
    logic        [N-1:0]  frac_c;
    logic        [TW-1:0] tail_c;
    logic        [1:0]    head_c;
    logic signed [VW-1:0] base_c, shifted_c;

    assign s_c    = SW'(s1_q.p) - SW'(FB);
    assign k_c    = s_c >>> ES;
    // Run length beyond the 2-bit seed: k for positive regimes, -k-1 for negative ones.
    assign sh_c   = k_c[SW-1] ? ~k_c : k_c;
    assign fs_c   = (PW+1)'(N) - {1'b0, s1_q.p};
    assign frac_c = s1_q.mag << fs_c;

    generate
        if (ES > 0) begin : g_exp
            assign tail_c = {s_c[ES-1:0], frac_c};
        end else begin : g_noexp
            assign tail_c = frac_c;
        end
    endgenerate

    // Seed "10" or "01" then sign-extend right so the leading bit repeats into the full regime.
    assign head_c    = k_c[SW-1] ? 2'b01 : 2'b10;
    assign base_c    = {head_c, tail_c, {PADW{1'b0}}};
    assign shifted_c = base_c >>> sh_c;

    always_comb begin
        s2_d.sign   = s1_q.sign;
        s2_d.zero   = s1_q.zero;
        s2_d.body   = shifted_c[VW-1 -: PN-1];
        s2_d.guard  = shifted_c[VW-PN];
        s2_d.sticky = |shifted_c[VW-PN-1:0];
    end

    // ---------------- S3: round, clamp, negate ----------------
    logic          rnd_c;
    logic [PN-1:0] sum_c;
    logic          ovf_c, unf_c;
    logic [PN-2:0] body_f;
    logic [PN-1:0] mag_p;

    assign rnd_c = s2_q.guard & (s2_q.sticky | s2_q.body[0]);
    assign sum_c = {1'b0, s2_q.body} + PN'(rnd_c);
    assign ovf_c = sum_c[PN-1];
    assign unf_c = ~ovf_c & (sum_c[PN-2:0] == '0);

    always_comb begin
        body_f = sum_c[PN-2:0];
        if (ovf_c)      body_f = '1;
        else if (unf_c) body_f = (PN-1)'(1);
    end

    assign mag_p   = {1'b0, body_f};
    assign posit_d = s2_q.zero ? '0 : (s2_q.sign ? (~mag_p + PN'(1)) : mag_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            posit_q <= '0;
        end else if (adv) begin
            v1      <= in_valid;
            v2      <= v1;
            v3      <= v2;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            posit_q <= posit_d;
        end
    end

`ifdef FX2P_STATUS_EN
    logic inexact_c, sat_c, inexact_q, sat_q;

    assign inexact_c   = ~s2_q.zero & (s2_q.guard | s2_q.sticky);
    assign sat_c       = ~s2_q.zero & (ovf_c | unf_c);
    assign out_inexact = inexact_q;
    assign out_sat     = sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inexact_q <= 1'b0;
            sat_q     <= 1'b0;
        end else if (adv) begin
            inexact_q <= inexact_c;
            sat_q     <= sat_c;
        end
    end
`endif

endmodule

// File: tb/tb_fixed_to_posit_pipe.sv
// Directed bench for fixed_to_posit_pipe: default 16-bit instance plus two 8-bit ES=0 instances.
module tb_fixed_to_posit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_fixed, out_posit;
    logic        bc_valid;
    logic        b_in_ready, c_in_ready, b_out_valid, c_out_valid;
    logic [7:0]  b_in, c_in, b_out, c_out;
`ifdef FX2P_STATUS_EN
    logic a_inexact, a_sat, b_inexact, b_sat, c_inexact, c_sat;
`endif

    fixed_to_posit_pipe #(.N(16), .FB(14), .PN(16), .ES(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fixed(in_fixed),
        .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
`ifdef FX2P_STATUS_EN
        , .out_inexact(a_inexact), .out_sat(a_sat)
`endif
    );

    fixed_to_posit_pipe #(.N(8), .FB(4), .PN(8), .ES(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(bc_valid), .in_ready(b_in_ready), .in_fixed(b_in),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_posit(b_out)
`ifdef FX2P_STATUS_EN
        , .out_inexact(b_inexact), .out_sat(b_sat)
`endif
    );

    fixed_to_posit_pipe #(.N(8), .FB(0), .PN(8), .ES(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(bc_valid), .in_ready(c_in_ready), .in_fixed(c_in),
        .out_valid(c_out_valid), .out_ready(1'b1), .out_posit(c_out)
`ifdef FX2P_STATUS_EN
        , .out_inexact(c_inexact), .out_sat(c_sat)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_q[$];
    int run    = 0;
    int vcount = 0;

    // Scoreboard: every handshaked output must match the oldest accepted word's expected posit.
    always @(negedge clk) begin
        if (!rst) begin
            run <= out_valid ? run + 1 : 0;
            if (out_valid) vcount <= vcount + 1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_when_idle", 32'(out_valid), 32'h0);
                else                   check("sb_posit", 32'(out_posit), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] x, input logic [15:0] e);
        bit ok;
        ok       = 1'b0;
        in_fixed = x;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) check("accept_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input logic [15:0] x, input logic [15:0] e, input string tag);
        send(x, e);
        @(negedge clk); check({tag, "_lat1"}, 32'(out_valid), 32'h0);
        @(negedge clk); check({tag, "_lat2"}, 32'(out_valid), 32'h0);
        @(negedge clk); check({tag, "_vld"}, 32'(out_valid), 32'h1);
        check({tag, "_posit"}, 32'(out_posit), 32'(e));
    endtask

    // Q1.14 inputs and posit16/es1 results derived by hand (e.g. -2.0: regime 10, exp 1 -> 0x5000, negated 0xB000).
    logic [15:0] vx [9] = '{16'h4000, 16'hC000, 16'h0000, 16'h8000, 16'h0001,
                            16'h2000, 16'h6000, 16'hA000, 16'hFFFF};
    logic [15:0] ve [9] = '{16'h4000, 16'hC000, 16'h0000, 16'hB000, 16'h0080,
                            16'h3000, 16'h4800, 16'hB800, 16'hFF80};

    logic [15:0] hold;
    int          unstable;
    int          vsnap;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fixed  = '0;
        out_ready = 1'b1;
        bc_valid  = 1'b0;
        b_in      = '0;
        c_in      = '0;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_posit", 32'(out_posit), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        tick(2);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 9; i++) begin
            single(vx[i], ve[i], $sformatf("vec%0d", i));
            tick(1);
        end

        // 1.99994 rounds up through the exponent to 2.0.
        single(16'h7FFF, 16'h5000, "round_carry");
`ifdef FX2P_STATUS_EN
        check("round_carry_inexact", 32'(a_inexact), 32'h1);
        check("round_carry_sat",     32'(a_sat),     32'h0);
`endif
        tick(2);

        send(16'h4000, 16'h4000);
        send(16'hC000, 16'hC000);
        send(16'h0001, 16'h0080);
        send(16'h8000, 16'hB000);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stream_run", 32'(run), 32'h4);
        tick(3);

        out_ready = 1'b0;
        send(16'h4000, 16'h4000);
        send(16'h0001, 16'h0080);
        send(16'h8000, 16'hB000);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready),  32'h0);
        check("stall_vld",      32'(out_valid), 32'h1);
        check("stall_head",     32'(out_posit), 32'h4000);
        hold     = out_posit;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_posit !== hold || out_valid !== 1'b1) unstable++;
        end
        check("stall_stable", 32'(unstable), 32'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick(6);
        check("drain_empty", 32'(exp_q.size()), 32'h0);

        send(16'h4000, 16'h4000);
        send(16'hC000, 16'hC000);
        send(16'h2000, 16'h3000);
        rst = 1'b1;
        #1;
        check("rst_mid_vld",   32'(out_valid), 32'h0);
        check("rst_mid_posit", 32'(out_posit), 32'h0);
        check("rst_mid_rdy",   32'(in_ready),  32'h1);
        exp_q.delete();
        vsnap = vcount;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(6);
        check("post_rst_quiet", 32'(vcount - vsnap), 32'h0);

        // B: 7.9375 rounds to 8.0 = 0x78; 2^-4 -> 0x04.  C (integers): -128 rounds past maxpos, clamps to 0x7F, negates to 0x81.
        bc_valid = 1'b1;
        b_in     = 8'h7F;
        c_in     = 8'h80;
        tick(1);
        b_in     = 8'h01;
        c_in     = 8'h7F;
        tick(1);
        bc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b0_vld",   32'(b_out_valid), 32'h1);
        check("b0_posit", 32'(b_out),       32'h78);
        check("c0_posit", 32'(c_out),       32'h81);
`ifdef FX2P_STATUS_EN
        check("b0_sat", 32'(b_sat), 32'h0);
        check("c0_sat", 32'(c_sat), 32'h1);
`endif
        @(negedge clk);
        check("b1_posit", 32'(b_out),       32'h04);
        check("c1_vld",   32'(c_out_valid), 32'h1);
        check("c1_posit", 32'(c_out),       32'h7F);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
